// File: rtl/lsu_unit.sv
// Load-store unit: turns core byte/half/word accesses into word-aligned memory requests and stalls until ready.
// Optional misaligned-access trap is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              lsu_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic [2:0] size_p0;
  logic [1:0] off_p0;

  // Sizes 3, 6 and 7 fall into the word case by default.
  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: store_be = 4'b0001 << off;
      3'd1, 3'd5: store_be = off[1] ? 4'b1100 : 4'b0011;
      default:    store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0, 3'd4: store_wd = {4{wd[7:0]}};
      3'd1, 3'd5: store_wd = {2{wd[15:0]}};
      default:    store_wd = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      3'd0:    load_fmt = {{24{b[7]}}, b};
      3'd4:    load_fmt = {24'd0, b};
      3'd1:    load_fmt = {{16{h[15]}}, h};
      3'd5:    load_fmt = {16'd0, h};
      default: load_fmt = rd;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0, 3'd4: misaligned = 1'b0;
      3'd1, 3'd5: misaligned = off[0];
      default:    misaligned = (off != 2'b00);
    endcase
  endfunction

  logic trap_c;
  assign trap_c = (state == S_IDLE) && core_req_i && misaligned(core_size_i, core_addr_i[1:0]);

  // Flag is high only for the DONE cycle that the trap jumps into.
  always_ff @(posedge clk) begin
    if (!rst_n) lsu_misalign_o <= 1'b0;
    else        lsu_misalign_o <= trap_c;
  end
`else
  logic trap_c;
  assign trap_c         = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  assign mem_req_o    = (state == S_WAIT);
  assign core_stall_o = ((state == S_IDLE) && core_req_i) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      size_p0    <= 3'd0;
      off_p0     <= 2'd0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= 4'd0;
      mem_addr_o <= '0;
      mem_wd_o   <= 32'd0;
      core_rd_o  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req_i) begin
            size_p0    <= core_size_i;
            off_p0     <= core_addr_i[1:0];
            mem_we_o   <= core_we_i;
            mem_be_o   <= store_be(core_size_i, core_addr_i[1:0]);
            mem_addr_o <= {core_addr_i[ADDR_W-1:2], 2'b00};
            mem_wd_o   <= store_wd(core_size_i, core_wd_i);
            if (trap_c) begin
              core_rd_o <= 32'd0;
              state     <= S_DONE;
            end else begin
              state     <= S_WAIT;
            end
          end
        end
        // Request fields stay frozen here; core inputs are ignored until DONE.
        S_WAIT: begin
          if (mem_ready_i) begin
            if (!mem_we_o) core_rd_o <= load_fmt(size_p0, off_p0, mem_rd_i);
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: expected memory requests and load results are queued at issue and checked on completion.
module tb_lsu_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, lsu_misalign;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  lsu_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .lsu_misalign_o(lsu_misalign),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  // Reference model used for randomised traffic (shift-based lane extraction).
  function automatic exp_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdata);
    exp_t        e;
    logic [31:0] lane;
    e.we   = we;
    e.addr = addr & 32'hFFFF_FFFC;
    if (size == 3'd0 || size == 3'd4) begin
      e.be = 4'(1) << addr[1:0];
      e.wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      lane = rdata >> (8 * addr[1:0]);
      e.rd = (size == 3'd4) ? (lane & 32'hFF) : 32'($signed(lane[7:0]));
    end else if (size == 3'd1 || size == 3'd5) begin
      e.be = 4'b0011 << (2 * addr[1]);
      e.wd = {wd[15:0], wd[15:0]};
      lane = rdata >> (16 * addr[1]);
      e.rd = (size == 3'd5) ? (lane & 32'hFFFF) : 32'($signed(lane[15:0]));
    end else begin
      e.be = 4'b1111;
      e.wd = wd;
      e.rd = rdata;
    end
    return e;
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                         input string name);
    exp_t e;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (core_stall !== 1'b1) begin
      errors++; $display("FAIL %s idle_stall: got %b expected 1", name, core_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: queue empty", name);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      core_addr = $urandom; core_wd = $urandom; core_size = 3'($urandom); core_we = 1'($urandom);
      checks++;
      if (mem_req !== 1'b1 || core_stall !== 1'b1 || mem_we !== e.we || mem_be !== e.be ||
          mem_addr !== e.addr || (e.we && mem_wd !== e.wd)) begin
        errors++;
        $display("FAIL %s wait%0d: req=%b stall=%b we=%b be=%b addr=%h wd=%h expected req=1 stall=1 we=%b be=%b addr=%h wd=%h",
                 name, c, mem_req, core_stall, mem_we, mem_be, mem_addr, mem_wd, e.we, e.be, e.addr, e.wd);
      end
      if (c == waits) begin mem_ready = 1'b1; mem_rd = rdata; end
      else            mem_rd = $urandom;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_rd = $urandom;
    if (!e.we) last_rd = e.rd;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_rd !== last_rd || lsu_misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s done: req=%b stall=%b rd=%h misalign=%b expected req=0 stall=0 rd=%h misalign=0",
               name, mem_req, core_stall, core_rd, lsu_misalign, last_rd);
    end
    core_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, lsu_misalign, core_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b be=%b addr=%h wd=%h rd=%h mis=%b stall=%b expected all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, lsu_misalign, core_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'd0;
  endtask

  task automatic test_store();
    sb.push_back('{1'b1, 4'b1111, 32'h104, 32'hDEADBEEF, 32'h0});
    run_txn(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 0, "sw");
    sb.push_back('{1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0});
    run_txn(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, "sb");
    sb.push_back('{1'b1, 4'b1100, 32'h200, 32'h5A5A5A5A, 32'h0});
    run_txn(1'b1, 3'd1, 32'h202, 32'h12345A5A, 32'h0, 1, "sh_hi");
  endtask

  task automatic test_load_ext();
    sb.push_back('{1'b0, 4'b0100, 32'h200, 32'h0, 32'hFFFFFFF4});
    run_txn(1'b0, 3'd0, 32'h202, 32'h0, 32'h12F45678, 0, "lb");
    sb.push_back('{1'b0, 4'b0100, 32'h200, 32'h0, 32'h000000F4});
    run_txn(1'b0, 3'd4, 32'h202, 32'h0, 32'h12F45678, 0, "lbu");
    sb.push_back('{1'b0, 4'b1100, 32'h200, 32'h0, 32'h000012F4});
    run_txn(1'b0, 3'd5, 32'h202, 32'h0, 32'h12F45678, 0, "lhu");
    sb.push_back('{1'b0, 4'b0011, 32'h200, 32'h0, 32'hFFFF8678});
    run_txn(1'b0, 3'd1, 32'h200, 32'h0, 32'h12F48678, 0, "lh_lo");
    sb.push_back('{1'b0, 4'b0010, 32'h200, 32'h0, 32'h00000056});
    run_txn(1'b0, 3'd0, 32'h201, 32'h0, 32'h12F45678, 0, "lb_lane1");
    // A store must leave the previous load value visible on core_rd_o.
    sb.push_back('{1'b1, 4'b0001, 32'h300, 32'h77777777, 32'h0});
    run_txn(1'b1, 3'd0, 32'h300, 32'h00000077, 32'h0, 0, "sb_hold_rd");
  endtask

  task automatic test_wait_states();
    sb.push_back('{1'b0, 4'b1111, 32'h400, 32'h0, 32'hCAFEF00D});
    run_txn(1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 5, "lw_wait5");
    sb.push_back('{1'b0, 4'b1111, 32'h404, 32'h0, 32'h80000001});
    run_txn(1'b0, 3'd7, 32'h404, 32'h0, 32'h80000001, 2, "size7_word");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h102;
    #1;
    checks++;
    if (core_stall !== 1'b1) begin
      errors++; $display("FAIL trap_idle_stall: got %b expected 1", core_stall);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || lsu_misalign !== 1'b1 || core_rd !== 32'd0 || core_stall !== 1'b0) begin
      errors++;
      $display("FAIL trap_done: req=%b mis=%b rd=%h stall=%b expected req=0 mis=1 rd=0 stall=0",
               mem_req, lsu_misalign, core_rd, core_stall);
    end
    core_req = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || lsu_misalign !== 1'b0) begin
      errors++; $display("FAIL trap_pulse_end: req=%b mis=%b expected req=0 mis=0", mem_req, lsu_misalign);
    end
`else
    sb.push_back('{1'b0, 4'b1111, 32'h100, 32'h0, 32'h11223344});
    run_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h11223344, 0, "lw_misalign");
    sb.push_back('{1'b1, 4'b0011, 32'h100, 32'hBEEFBEEF, 32'h0});
    run_txn(1'b1, 3'd1, 32'h101, 32'h0000BEEF, 32'h0, 0, "sh_misalign");
`endif
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h500; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_entry: req=%b expected 1", mem_req);
    end
    rst_n = 1'b0; core_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || core_rd !== 32'd0 || core_stall !== 1'b0 || mem_be !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid_wait: req=%b rd=%h stall=%b be=%b expected req=0 rd=0 stall=0 be=0",
               mem_req, core_rd, core_stall, mem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'd0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_abandon: req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr, wd, rdata;
      we    = 1'($urandom);
      size  = 3'($urandom_range(0, 7));
      addr  = $urandom & 32'h0000_FFFF;
      wd    = $urandom;
      rdata = $urandom;
      if (size == 3'd1 || size == 3'd5) addr[0] = 1'b0;
      else if (size != 3'd0 && size != 3'd4) addr[1:0] = 2'b00;
      sb.push_back(model(we, size, addr, wd, rdata));
      run_txn(we, size, addr, wd, rdata, $urandom_range(0, 3), "rand");
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_store();
        test_load_ext();
        test_wait_states();
        test_misalign();
        test_reset_mid_wait();
        test_back_to_back();
      end
      begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
